// File: rtl/btn_pkg.sv
// Shared defaults, repeat-state encoding and counter sizing helper for the
// push-button debouncer.
package btn_pkg;

   localparam int unsigned NUM_BTN_DEF         = 4;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned HOLD_CYCLES_DEF     = 50_000_000;
   localparam int unsigned REPEAT_CYCLES_DEF   = 10_000_000;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_HOLD   = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   // Width needed to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, press strobe and,
// with BTN_AUTOREPEAT_EN defined, a hold/auto-repeat sequencer.
//
//   state      | meaning
//   RPT_IDLE   | debounced level low, no timing in progress
//   RPT_HOLD   | pressed, timer counting down the initial hold time
//   RPT_REPEAT | hold time elapsed, timer counting down each repeat period
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int unsigned     DB_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            pulse_q, pulse_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            accept;
   logic            rise;

   always_comb begin
      db_cnt_d = '0;
      accept   = 1'b0;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_TC) begin
            accept = 1'b1;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
      level_d = accept ? sync2_q : level_q;
   end

   assign rise = accept & sync2_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned      TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned      TMR_W   = cnt_width(TMR_MAX);
   localparam logic [TMR_W-1:0] HOLD_TC = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REP_TC  = TMR_W'(REPEAT_CYCLES - 1);

   rpt_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             fall;
   logic             rpt_fire;

   assign fall = accept & ~sync2_q;

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      rpt_fire = 1'b0;
      case (state_q)
         RPT_IDLE: begin
            if (rise) begin
               state_d = RPT_HOLD;
               tmr_d   = HOLD_TC;
            end
         end
         RPT_HOLD, RPT_REPEAT: begin
            // A release on this edge wins over a repeat that would fire with it.
            if (fall) begin
               state_d = RPT_IDLE;
               tmr_d   = '0;
            end else if (tmr_q == '0) begin
               rpt_fire = 1'b1;
               state_d  = RPT_REPEAT;
               tmr_d    = REP_TC;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = RPT_IDLE;
            tmr_d   = '0;
         end
      endcase
      pulse_d = (rise | rpt_fire) & ~pulse_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RPT_IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end
`else
   assign pulse_d = rise;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         db_cnt_q <= '0;
         pulse_q  <= 1'b0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         level_q  <= level_d;
         db_cnt_q <= db_cnt_d;
         pulse_q  <= pulse_d;
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer with registered press strobes.
// Define BTN_AUTOREPEAT_EN to add hold-then-repeat strobes on held buttons.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_i   (btn[i]),
         .level_o (btn_level[i]),
         .pulse_o (btn_pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed vector table, multi-cycle corner
// sequences and random bouncing input against a sliding-window model.
module tb_btn_debounce;

   localparam int NB   = 4;
   localparam int DB   = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pulse;

   always #5 clk = ~clk;

   btn_debounce #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: hist[0] is the raw sample of the previous edge,
   // hist[j] the one j edges further back. A level flips once the DB samples
   // that have reached the synchronizer output all disagree with it.
   logic [NB-1:0] hist [DB+1];
   logic [NB-1:0] m_level;
   logic [NB-1:0] m_pulse;
   int            rise_edge [NB];
   int            edge_no = 0;

   task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual %b required %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j <= DB; j++) hist[j] = '0;
      m_level = '0;
      m_pulse = '0;
   endtask

   task automatic model_step(input logic [NB-1:0] b);
      logic [NB-1:0] nl;
      logic [NB-1:0] np;
      bit            all_diff;
      bit            falling;
      int            t;
      nl = m_level;
      np = '0;
      for (int ch = 0; ch < NB; ch++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= DB; j++)
            if (hist[j][ch] == m_level[ch]) all_diff = 1'b0;
         falling = all_diff && m_level[ch];
         if (all_diff) nl[ch] = ~m_level[ch];
         if (all_diff && !m_level[ch]) begin
            np[ch]        = 1'b1;
            rise_edge[ch] = edge_no;
         end
`ifdef BTN_AUTOREPEAT_EN
         else if (m_level[ch] && !falling) begin
            t = edge_no - rise_edge[ch];
            if (t == HOLD || (t > HOLD && ((t - HOLD) % REP) == 0)) np[ch] = 1'b1;
         end
`endif
         if (m_pulse[ch]) np[ch] = 1'b0;
      end
      for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = b;
      m_level = nl;
      m_pulse = np;
      edge_no++;
   endtask

   // One clock edge: advance the model with the value the DUT sampled,
   // then compare both outputs 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else        model_step(btn);
      check("model_level", btn_level, m_level);
      check("model_pulse", btn_pulse, m_pulse);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [NB-1:0] b;
      logic [NB-1:0] lvl;
      logic [NB-1:0] pls;
   } vec_t;

   vec_t vt [9];
   int   got_q [$];
   int   exp_q [$];
   logic [NB-1:0] mask;
   int   div;

   initial begin
      vt[0] = '{4'b0001, 4'b0000, 4'b0000};
      vt[1] = '{4'b0001, 4'b0000, 4'b0000};
      vt[2] = '{4'b0001, 4'b0000, 4'b0000};
      vt[3] = '{4'b0001, 4'b0000, 4'b0000};
      vt[4] = '{4'b0001, 4'b0000, 4'b0000};
      vt[5] = '{4'b0001, 4'b0001, 4'b0001};
      vt[6] = '{4'b0001, 4'b0001, 4'b0000};
      vt[7] = '{4'b0001, 4'b0001, 4'b0000};
      vt[8] = '{4'b0001, 4'b0001, 4'b0000};

      // Reset state
      do_reset();
      #1;
      check("reset_level", btn_level, 4'b0000);
      check("reset_pulse", btn_pulse, 4'b0000);

      // Single press on channel 0, table driven
      for (int e = 0; e < 9; e++) begin
         btn = vt[e].b;
         tick();
         check("press0_level", btn_level, vt[e].lvl);
         check("press0_pulse", btn_pulse, vt[e].pls);
      end

      // Glitch of 3 cycles on channel 1 is rejected
      do_reset();
      btn = 4'b0010;
      for (int e = 0; e < 16; e++) begin
         if (e == 3) btn = 4'b0000;
         tick();
         check("glitch_level", btn_level, 4'b0000);
         check("glitch_pulse", btn_pulse, 4'b0000);
      end

      // Release of channel 2: level falls 5 edges later, no pulse
      do_reset();
      btn = 4'b0100;
      repeat (8) tick();
      check("rel_pre_level", btn_level, 4'b0100);
      btn = 4'b0000;
      for (int e = 0; e < 8; e++) begin
         tick();
         check("rel_level", btn_level, (e >= 5) ? 4'b0000 : 4'b0100);
         check("rel_pulse", btn_pulse, 4'b0000);
      end

      // Simultaneous presses on channels 1 and 3
      do_reset();
      btn = 4'b1010;
      for (int e = 0; e < 8; e++) begin
         tick();
         check("multi_pulse", btn_pulse, (e == 5) ? 4'b1010 : 4'b0000);
      end

      // Asynchronous reset with a debounced level high, then button still held
      do_reset();
      btn = 4'b0001;
      repeat (7) tick();
      check("async_pre_level", btn_level, 4'b0001);
      #1 rst_n = 1'b0;
      #1;
      check("async_level", btn_level, 4'b0000);
      check("async_pulse", btn_pulse, 4'b0000);
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         check("held_rst_pulse", btn_pulse, (e == 5) ? 4'b0001 : 4'b0000);
      end

      // Reset at edge 3 of a press discards the partial count
      do_reset();
      btn = 4'b0010;
      repeat (4) tick();
      #1 rst_n = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         check("midcnt_pulse", btn_pulse, (e == 5) ? 4'b0010 : 4'b0000);
         check("midcnt_level", btn_level, (e >= 5) ? 4'b0010 : 4'b0000);
      end

      // Channel 3 held 60 cycles: pulse edges
      do_reset();
      btn = 4'b1000;
      got_q.delete();
      for (int e = 0; e < 100; e++) begin
         if (e == 60) btn = 4'b0000;
         tick();
         if (btn_pulse[3]) got_q.push_back(e);
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_q = '{5, 25, 33, 41, 49, 57};
`else
      exp_q = '{5};
`endif
      check_int("hold_pulse_count", got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         check_int("hold_pulse_edge", (k < got_q.size()) ? got_q[k] : -1, exp_q[k]);

      // Random bouncing stimulus against the model
      do_reset();
      div = 12;
      for (int c = 0; c < 3000; c++) begin
         if (c % 60 == 0) div = ($urandom_range(0, 2) == 0) ? 2 : 12;
         mask = '0;
         for (int i = 0; i < NB; i++)
            if ($urandom_range(0, div - 1) == 0) mask[i] = 1'b1;
         btn = btn ^ mask;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, cycles a new level must hold before acceptance (10 ms at 100 MHz).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50000000, held-time before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat pulse period.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port btn  input  NUM_BTN  raw, asynchronous, bouncing button levels, 1 = pressed.
REQ-008 SHALL have port btn_level  output  NUM_BTN  debounced level per channel.
REQ-009 SHALL have port btn_pulse  output  NUM_BTN  one-clk press strobe per channel, for the downstream digit-increment stage.

Function
REQ-010 SHALL pass each btn bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL keep, per channel, a counter of width clog2(DEBOUNCE_CYCLES); counter cleared on any cycle where sync2 == btn_level.
REQ-012 SHALL, while sync2 != btn_level, increment the counter; on the edge where the counter equals DEBOUNCE_CYCLES-1, load btn_level <= sync2 and clear the counter.
REQ-013 SHALL make btn_level change exactly DEBOUNCE_CYCLES+1 edges after the first edge sampling a stable new btn value.
REQ-014 SHALL reject any input excursion shorter than DEBOUNCE_CYCLES cycles (post-synchronizer): no btn_level change, no btn_pulse.
REQ-015 SHALL assert btn_pulse[i] for exactly one cycle, registered, on the same edge btn_level[i] goes 0->1; never on 1->0.
REQ-016 SHALL operate channels fully independently; simultaneous presses on several channels produce simultaneous pulses.
REQ-017 SHALL never assert btn_pulse on two consecutive cycles for one channel, regardless of input.
REQ-018 SHALL not wrap any counter: debounce counter saturates by clearing (REQ-012); hold/repeat counters stop at their terminal values.

Reset
REQ-019 SHALL, while rst_n = 0, force sync1, sync2, btn_level, btn_pulse, all counters to 0, immediately and independent of clk.
REQ-020 SHALL, on rst_n deassertion with a button already held, treat it as a fresh press: pulse after DEBOUNCE_CYCLES+1 edges.
REQ-021 SHALL discard any partial debounce count when reset asserts mid-count.

Configuration
REQ-022 SHALL, when macro BTN_AUTOREPEAT_EN is defined, per channel count cycles with btn_level = 1; after HOLD_CYCLES emit btn_pulse, then one further pulse every REPEAT_CYCLES while held; counters clear when btn_level falls.
REQ-023 SHALL, when BTN_AUTOREPEAT_EN is undefined, emit only the single press pulse of REQ-015, with no hold/repeat counter logic synthesized; HOLD_CYCLES and REPEAT_CYCLES ignored.

Structure
REQ-024 SHALL place NUM_BTN default and the debounce/hold/repeat default constants in shared package btn_pkg.
REQ-025 SHALL implement one channel (synchronizer, debounce counter, pulse, optional repeat) in sub-module btn_debounce_ch, instantiated NUM_BTN times by generate.

Verification (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-026 SHALL cover: btn=4'b0001 held from edge 0 -> btn_level[0]=1 and btn_pulse=4'b0001 for one cycle at edge 5; btn_pulse=0 thereafter (macro off).
REQ-027 SHALL cover: btn[1] high for 3 cycles then low -> btn_level and btn_pulse stay 0 throughout.
REQ-028 SHALL cover: btn[2] 1->0 after stable press -> btn_level[2] falls 5 edges later, btn_pulse[2] stays 0.
REQ-029 SHALL cover: btn=4'b1010 applied in one cycle -> btn_pulse=4'b1010 in a single cycle at edge 5.
REQ-030 SHALL cover: rst_n pulsed low at edge 3 of a press -> all outputs 0 asynchronously; pulse 5 edges after rst_n rises.
REQ-031 SHALL cover (BTN_AUTOREPEAT_EN): btn[3] held 60 cycles -> pulses at edge 5, 25, 33, 41, 49, 57; none after release.
